// File: rtl/dma_write_engine.sv
// Memory-write DMA engine: pops 32-bit result words, packs them into 64-bit
// beats (first popped word in the upper half) and writes them as AXI bursts.
module dma_write_engine #(
  parameter int MAX_BURST = 8,
  parameter int FIFO_LAT  = 1
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        dma_enable_i,
  input  logic [31:0] dma_base_addr_i,
  input  logic [31:0] dma_bit_len_i,
  input  logic        dma_start_i,
  output logic        fifo_rd_en_o,
  input  logic [31:0] fifo_rd_out_i,
  input  logic [8:0]  fifo_rd_count_i,
  output logic        axi_clk_o,
  output logic        axi_rstn_o,
  output logic [31:0] axi_waddr_o,
  output logic [63:0] axi_wdata_o,
  output logic [7:0]  axi_wsel_o,
  output logic        axi_wvalid_o,
  output logic [3:0]  axi_wlen_o,
  output logic        axi_wfixed_o,
  input  logic        axi_werr_i,
  input  logic        axi_wrdy_i,
  output logic        dma_busy_o,
  output logic        dma_done_o,
  output logic        dma_err_o,
  output logic [3:0]  dbg_state_o
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'h0,
    S_ARM    = 4'h1,
    S_RD_HI  = 4'h2,
    S_LAT_HI = 4'h3,
    S_LAT_LO = 4'h4,
    S_BEAT   = 4'h5,
    S_DONE   = 4'h6,
    S_ERR    = 4'hF
  } state_e;

  localparam logic [5:0] BURST_CAP = 6'(2 * MAX_BURST);

  // The pop/latch state sequence assumes exactly one cycle of FIFO read latency.
  if (MAX_BURST < 1 || MAX_BURST > 16 || FIFO_LAT != 1) begin : g_param_check
    $error("dma_write_engine: MAX_BURST must be 1..16 and FIFO_LAT must be 1");
  end

  state_e      state;
  state_e      state_nxt;
  logic        start_q;
  logic [31:0] base_q;
  logic [31:0] ofs_addr;
  logic [27:0] rem_words;
  logic [4:0]  beats_left;

  logic [32:0] len_sum;
  logic [27:0] rem_init;
  logic [5:0]  burst_words;
  logic [4:0]  burst_beats;
  logic        fifo_ready;
  logic        start_evt;
  logic        more_words;

  assign len_sum     = {1'b0, dma_bit_len_i} + 33'd31;
  assign rem_init    = 28'(len_sum >> 5);
  assign burst_words = (rem_words < 28'(BURST_CAP)) ? rem_words[5:0] : BURST_CAP;
  assign burst_beats = 5'((7'(burst_words) + 7'd1) >> 1);
  assign fifo_ready  = fifo_rd_count_i >= 9'(burst_words);
  assign start_evt   = dma_start_i && !start_q && dma_enable_i && (|dma_bit_len_i);
  assign more_words  = rem_words > 28'd1;

  assign axi_clk_o    = clk_i;
  assign axi_rstn_o   = rstn_i;
  assign axi_wfixed_o = 1'b0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    if (state != S_IDLE && state != S_ERR && axi_werr_i) begin
      state_nxt = S_ERR;
    end else begin
      case (state)
        S_IDLE:   if (start_evt) state_nxt = S_ARM;
        S_ARM: begin
          if (!dma_enable_i)   state_nxt = S_IDLE;
          else if (fifo_ready) state_nxt = S_RD_HI;
        end
        S_RD_HI:  state_nxt = S_LAT_HI;
        S_LAT_HI: state_nxt = more_words ? S_LAT_LO : S_BEAT;
        S_LAT_LO: state_nxt = S_BEAT;
        S_BEAT: begin
          if (axi_wrdy_i) begin
            if (beats_left > 5'd1)       state_nxt = S_RD_HI;
            else if (rem_words != 28'd0) state_nxt = S_ARM;
            else                         state_nxt = S_DONE;
          end
        end
        S_DONE:   state_nxt = S_IDLE;
        S_ERR:    if (!dma_enable_i) state_nxt = S_IDLE;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    fifo_rd_en_o = 1'b0;
    axi_wvalid_o = 1'b0;
    dma_busy_o   = 1'b0;
    dma_done_o   = 1'b0;
    dma_err_o    = 1'b0;
    dbg_state_o  = state;
    case (state)
      S_RD_HI:  fifo_rd_en_o = 1'b1;
      S_LAT_HI: fifo_rd_en_o = more_words;
      S_BEAT:   axi_wvalid_o = 1'b1;
      S_DONE:   dma_done_o   = 1'b1;
      S_ERR:    dma_err_o    = 1'b1;
      default:  ;
    endcase
    dma_busy_o = (state != S_IDLE) && (state != S_ERR);
  end

  // Datapath: job counters, burst header and beat assembly.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      start_q     <= 1'b0;
      base_q      <= '0;
      ofs_addr    <= '0;
      rem_words   <= '0;
      beats_left  <= '0;
      axi_waddr_o <= '0;
      axi_wdata_o <= '0;
      axi_wsel_o  <= '0;
      axi_wlen_o  <= '0;
    end else begin
      start_q <= dma_start_i;
      case (state)
        S_IDLE: begin
          if (start_evt) begin
            base_q    <= dma_base_addr_i & ~32'h7;
            rem_words <= rem_init;
            ofs_addr  <= '0;
          end
        end
        S_ARM: begin
          axi_waddr_o <= base_q + ofs_addr;
          axi_wlen_o  <= 4'(burst_beats - 5'd1);
          beats_left  <= burst_beats;
        end
        S_LAT_HI: begin
          axi_wdata_o[63:32] <= fifo_rd_out_i;
          rem_words          <= rem_words - 28'd1;
          if (!more_words) begin
            axi_wdata_o[31:0] <= '0;
            axi_wsel_o        <= 8'hF0;
          end
        end
        S_LAT_LO: begin
          axi_wdata_o[31:0] <= fifo_rd_out_i;
          axi_wsel_o        <= 8'hFF;
          rem_words         <= rem_words - 28'd1;
        end
        S_BEAT: begin
          // A write error in the same cycle wins: the beat is not counted.
          if (axi_wrdy_i && !axi_werr_i) begin
            ofs_addr   <= ofs_addr + 32'd8;
            beats_left <= beats_left - 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
